// File: rtl/call_panel_if.sv
// Floor call panel bus: raw buttons and car status in, latched calls out.
interface call_panel_if;
   logic       btn1;
   logic       btn2;
   logic       btn3;
   logic       floor1;
   logic       floor2;
   logic       floor3;
   logic       door;
   logic       moving;
   logic       led1;
   logic       led2;
   logic       led3;
   logic [1:0] pending;
   logic       fault;

   modport master (
      output btn1, btn2, btn3,
      output floor1, floor2, floor3,
      output door, moving,
      input  led1, led2, led3,
      input  pending, fault
   );

   modport slave (
      input  btn1, btn2, btn3,
      input  floor1, floor2, floor3,
      input  door, moving,
      output led1, led2, led3,
      output pending, fault
   );
endinterface

// File: rtl/call_panel.sv
// Three-floor call latch: sync, optional debounce, set on press, clear on service.
// Optional debounce filter enabled by defining CALL_PANEL_DEBOUNCE_EN.
module call_panel #(
   parameter int DEBOUNCE_CYCLES = 3,
   parameter int CLEAR_HOLD      = 2
) (
   input logic         clk_50,
   input logic         rst,
   call_panel_if.slave bus
);

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_db_range
      $error("DEBOUNCE_CYCLES out of range");
   end
   if (CLEAR_HOLD < 1 || CLEAR_HOLD > 15) begin : g_hold_range
      $error("CLEAR_HOLD out of range");
   end

   localparam logic [3:0] HOLD_MAX = 4'(CLEAR_HOLD);
   localparam logic [3:0] HOLD_PRE = 4'(CLEAR_HOLD - 1);

   logic [2:0] btn;
   logic [2:0] flr;
   logic [2:0] s1;
   logic [2:0] s2;
   logic [1:0] vld;
   logic [2:0] cond;
   logic [2:0] prev;
   logic [2:0] armed;
   logic [2:0] rise;
   logic [2:0] served;
   logic [2:0] reach;
   logic [2:0] led_q;
   logic [2:0] led_d;
   logic [3:0] hold [3];
   logic [1:0] pend_q;
   logic       invalid;
   logic       fault_q;

   assign btn = {bus.btn3, bus.btn2, bus.btn1};
   assign flr = {bus.floor3, bus.floor2, bus.floor1};

   assign invalid = (flr[0] & flr[1]) |
                    (flr[0] & flr[2]) |
                    (flr[1] & flr[2]);

   always_ff @(posedge clk_50 or posedge rst) begin
      if (rst) begin
         s1  <= '0;
         s2  <= '0;
         vld <= '0;
      end else begin
         s1  <= btn;
         s2  <= s1;
         vld <= {vld[0], 1'b1};
      end
   end

`ifdef CALL_PANEL_DEBOUNCE_EN
   localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

   logic [2:0] lvl;
   logic [7:0] cnt [3];

   always_ff @(posedge clk_50 or posedge rst) begin
      if (rst) begin
         lvl <= '0;
         for (int i = 0; i < 3; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (s2[i] == lvl[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DB_LAST) begin
               lvl[i] <= s2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 8'd1;
            end
         end
      end
   end

   assign cond = lvl;
`else
   assign cond = s2;
`endif

   // A button only arms once a released level has passed the synchronizer
   // after reset, so a button held through reset cannot raise a call.
   always_ff @(posedge clk_50 or posedge rst) begin
      if (rst) begin
         prev  <= '0;
         armed <= '0;
      end else begin
         prev  <= cond;
         armed <= armed | (~s2 & {3{vld[1]}});
      end
   end

   assign rise = cond & ~prev & armed;

   always_comb begin
      served = '0;
      reach  = '0;
      for (int i = 0; i < 3; i++) begin
         served[i] = flr[i] & bus.door & ~bus.moving & ~invalid & ~fault_q;
         reach[i]  = served[i] & (hold[i] == HOLD_PRE);
      end
   end

   always_ff @(posedge clk_50 or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) hold[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (!served[i]) hold[i] <= '0;
            else if (hold[i] != HOLD_MAX) hold[i] <= hold[i] + 4'd1;
         end
      end
   end

   assign led_d = (led_q | (rise & ~served)) & ~reach;

   always_ff @(posedge clk_50 or posedge rst) begin
      if (rst) begin
         led_q   <= '0;
         pend_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         led_q   <= led_d;
         pend_q  <= {1'b0, led_d[0]} + {1'b0, led_d[1]} + {1'b0, led_d[2]};
         fault_q <= invalid;
      end
   end

   assign bus.led1    = led_q[0];
   assign bus.led2    = led_q[1];
   assign bus.led3    = led_q[2];
   assign bus.pending = pend_q;
   assign bus.fault   = fault_q;

endmodule

// File: tb/tb_call_panel.sv
// Directed bench for call_panel: set/clear, service, fault and reset behaviour.
module tb_call_panel;

   logic clk_50 = 1'b0;
   logic rst    = 1'b1;

   always #5 clk_50 = ~clk_50;

   call_panel_if bus ();

   call_panel #(
      .DEBOUNCE_CYCLES(3),
      .CLEAR_HOLD     (2)
   ) dut (
      .clk_50(clk_50),
      .rst   (rst),
      .bus   (bus.slave)
   );

`ifdef CALL_PANEL_DEBOUNCE_EN
   localparam int LAT = 6;
   localparam int PW  = 6;
`else
   localparam int LAT = 3;
   localparam int PW  = 1;
`endif

   int n_cmp = 0;
   int n_err = 0;

   task automatic tick();
      @(posedge clk_50);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_btn(input int n, input logic v);
      case (n)
         1: bus.btn1 = v;
         2: bus.btn2 = v;
         default: bus.btn3 = v;
      endcase
   endtask

   task automatic press(input int n);
      set_btn(n, 1'b1);
      repeat (LAT) tick();
      set_btn(n, 1'b0);
      repeat (LAT + 2) tick();
   endtask

   initial begin
      bus.btn1   = 1'b0;
      bus.btn2   = 1'b0;
      bus.btn3   = 1'b0;
      bus.floor1 = 1'b0;
      bus.floor2 = 1'b0;
      bus.floor3 = 1'b0;
      bus.door   = 1'b0;
      bus.moving = 1'b0;

      #12;
      chk("reset_leds", {5'd0, bus.led3, bus.led2, bus.led1}, 8'd0);
      chk("reset_pending", {6'd0, bus.pending}, 8'd0);
      chk("reset_fault", {7'd0, bus.fault}, 8'd0);
      tick();
      rst = 1'b0;
      repeat (4) tick();

      // Single press on floor 3
      bus.btn3 = 1'b1;
      for (int k = 1; k <= LAT; k++) begin
         tick();
         if (k == PW) bus.btn3 = 1'b0;
         if (k == LAT - 1) chk("btn3_early", {7'd0, bus.led3}, 8'd0);
      end
      chk("btn3_set", {7'd0, bus.led3}, 8'd1);
      chk("btn3_pend", {6'd0, bus.pending}, 8'd1);
      chk("btn3_others", {6'd0, bus.led2, bus.led1}, 8'd0);
      repeat (4) tick();

`ifdef CALL_PANEL_DEBOUNCE_EN
      bus.btn2 = 1'b1;
      repeat (2) tick();
      bus.btn2 = 1'b0;
      repeat (8) tick();
      chk("glitch_led2", {7'd0, bus.led2}, 8'd0);
`endif

      // Held press on floor 2
      bus.btn2 = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == LAT - 1) chk("hold2_early", {7'd0, bus.led2}, 8'd0);
         if (k == LAT) chk("hold2_set", {7'd0, bus.led2}, 8'd1);
      end
      bus.btn2 = 1'b0;
      repeat (8) tick();
      chk("hold2_single", {6'd0, bus.pending}, 8'd2);

      // Floor 1 call and clear after service
      press(1);
      chk("led1_set", {7'd0, bus.led1}, 8'd1);
      chk("all_pend", {6'd0, bus.pending}, 8'd3);
      bus.floor1 = 1'b1;
      bus.door   = 1'b1;
      tick();
      chk("serve1_hold1", {7'd0, bus.led1}, 8'd1);
      tick();
      chk("serve1_clear", {7'd0, bus.led1}, 8'd0);
      chk("serve1_pend", {6'd0, bus.pending}, 8'd2);
      bus.floor1 = 1'b0;
      bus.door   = 1'b0;
      tick();

      // Service interrupted, then door open while moving
      press(1);
      chk("led1_reset", {7'd0, bus.led1}, 8'd1);
      bus.floor1 = 1'b1;
      bus.door   = 1'b1;
      tick();
      bus.door = 1'b0;
      repeat (2) tick();
      chk("door_drop", {7'd0, bus.led1}, 8'd1);
      bus.door   = 1'b1;
      bus.moving = 1'b1;
      repeat (3) tick();
      chk("door_moving", {7'd0, bus.led1}, 8'd1);
      bus.door   = 1'b0;
      bus.moving = 1'b0;
      bus.floor1 = 1'b0;
      tick();

      // Press while served is ignored
      bus.floor2 = 1'b1;
      bus.door   = 1'b1;
      repeat (2) tick();
      chk("serve2_clear", {7'd0, bus.led2}, 8'd0);
      press(2);
      chk("served_press", {7'd0, bus.led2}, 8'd0);
      bus.door = 1'b0;
      press(2);
      chk("door_closed_press", {7'd0, bus.led2}, 8'd1);
      bus.floor2 = 1'b0;
      tick();
      chk("three_pend", {6'd0, bus.pending}, 8'd3);

      // Invalid floor inputs
      bus.floor1 = 1'b1;
      bus.floor3 = 1'b1;
      bus.door   = 1'b1;
      tick();
      chk("fault_set", {7'd0, bus.fault}, 8'd1);
      repeat (2) tick();
      chk("fault_leds", {6'd0, bus.led3, bus.led1}, 8'd3);
      bus.floor1 = 1'b0;
      tick();
      chk("fault_clear", {7'd0, bus.fault}, 8'd0);
      chk("after_fault_a", {7'd0, bus.led3}, 8'd1);
      tick();
      chk("after_fault_b", {7'd0, bus.led3}, 8'd1);
      tick();
      chk("after_fault_c", {7'd0, bus.led3}, 8'd0);
      chk("after_fault_pend", {6'd0, bus.pending}, 8'd2);
      bus.door   = 1'b0;
      bus.floor3 = 1'b0;
      tick();

      // Asynchronous reset mid-count
      bus.btn1 = 1'b1;
      bus.btn2 = 1'b1;
      bus.btn3 = 1'b1;
      repeat (2) tick();
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst",
          {2'd0, bus.fault, bus.pending, bus.led3, bus.led2, bus.led1}, 8'd0);
      repeat (2) tick();
      bus.btn2 = 1'b0;
      bus.btn3 = 1'b0;
      rst      = 1'b0;
      repeat (12) tick();
      chk("held_thru_rst", {5'd0, bus.led3, bus.led2, bus.led1}, 8'd0);
      bus.btn1 = 1'b0;
      repeat (LAT + 4) tick();
      press(1);
      chk("repress_led1", {7'd0, bus.led1}, 8'd1);
      chk("repress_pend", {6'd0, bus.pending}, 8'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/call_panel.md
CALL_PANEL -- requirements
Module: call_panel

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 3, meaning consecutive stable cycles required before a button level is accepted (range 1-255).
REQ-002 SHALL have parameter CLEAR_HOLD, default 2, meaning consecutive cycles the car must be served at a floor before its call clears (range 1-15).
REQ-003 SHALL have port clk_50, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; it is asynchronous and active-high.
REQ-005 SHALL have ports btn1, btn2, btn3, input, 1 each, meaning raw asynchronous floor call buttons, active-high.
REQ-006 SHALL have ports floor1, floor2, floor3, input, 1 each, meaning the car-position one-hot from the elevator controller.
REQ-007 SHALL have port door, input, 1, meaning door open.
REQ-008 SHALL have port moving, input, 1, meaning car in motion.
REQ-009 SHALL have ports led1, led2, led3, output, 1 each, meaning latched pending call per floor, registered, driven to the elevator controller.
REQ-010 SHALL have port pending, output, 2, meaning the count of asserted led bits (0-3), registered.
REQ-011 SHALL have port fault, output, 1, meaning the floor inputs are not one-hot-or-zero, registered.

Function
REQ-012 SHALL pass each btnN through a 2-flop synchronizer before any use.
REQ-013 SHALL set ledN on a rising edge of the conditioned btnN; a held button sets ledN once.
REQ-014 SHALL define "served N" as floorN=1, door=1, moving=0, fault=0.
REQ-015 SHALL ignore a rising edge of btnN arriving while served N is true, leaving ledN at 0.
REQ-016 SHALL keep a per-floor hold counter that increments while served N and resets to 0 when it is false, saturating at CLEAR_HOLD.
REQ-017 SHALL clear ledN on the edge at which the hold counter reaches CLEAR_HOLD.
REQ-018 SHALL give clear priority over set when both occur for the same floor in the same cycle.
REQ-019 SHALL keep setting a request for one floor independent of the other floors; all three may be pending at once.
REQ-020 SHALL assert fault one cycle after more than one floorN is 1, and deassert it one cycle after the condition ends.
REQ-021 SHALL inhibit all clears and reset all hold counters while the floor inputs are invalid; sets continue normally.
REQ-022 SHALL update pending in the same cycle that the led bits change, as the registered popcount of the next led values.
REQ-023 SHALL treat door=1 with moving=1 as not served, so no clear occurs.

Reset
REQ-024 SHALL drive led1-3=0, pending=0, fault=0, and all synchronizer, debounce and hold state to 0 immediately when rst=1, without waiting for clk_50.
REQ-025 SHALL start operating on the first clk_50 edge after rst falls; a button held through reset SHALL NOT create a call until it is released and pressed again.
REQ-026 SHALL discard any in-progress debounce or hold count when reset is asserted mid-operation.

Configuration
REQ-027 SHALL, when CALL_PANEL_DEBOUNCE_EN is defined, accept a synchronized button level only after it has been stable for DEBOUNCE_CYCLES consecutive cycles, using a per-button counter that restarts on any change. Latency from btnN first sampled high to ledN=1 is 3+DEBOUNCE_CYCLES clk_50 edges.
REQ-028 SHALL, without CALL_PANEL_DEBOUNCE_EN, feed the synchronizer output directly to edge detection, with latency of 3 clk_50 edges (the sampling edge counts as 1). DEBOUNCE_CYCLES SHALL then be unused.

Verification
REQ-029 Reset then a 1-cycle pulse on btn3 with the macro off -> led3=1 after the 3rd edge, pending=1; led1=led2=0.
REQ-030 Macro on with DEBOUNCE_CYCLES=3; a 2-cycle glitch on btn2, then btn2 held 6 cycles -> no set from the glitch, led2=1 exactly 6 edges after the held press starts, single set.
REQ-031 led1=1, then floor1=1, door=1, moving=0 held 2 cycles with CLEAR_HOLD=2 -> led1=0 after the 2nd edge. Repeat with door dropping after 1 cycle -> led1 stays 1.
REQ-032 Press btn2 while floor2=1, door=1, moving=0 -> led2 stays 0; press btn2 with door=0 -> led2=1.
REQ-033 floor1=floor3=1, door=1, moving=0 with led1=led3=1 -> fault=1 next cycle and both leds stay 1; on return to floor3 only, fault=0 and led3 clears after CLEAR_HOLD.
REQ-034 Press all three buttons, then assert rst asynchronously mid-count -> leds, pending and fault go to 0 immediately; a btn1 held across reset gives no set until re-pressed.
